// File: rtl/rb1_port_arbiter_pkg.sv
// rb1_port_arbiter_pkg: shared widths, range limit, arbitration state codes and bank command encoding
package rb1_port_arbiter_pkg;
  localparam int RB_AW = 5;
  localparam int RB_DW = 8;
  localparam int RB_ADDR_MAX = 17;
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_UNLOCKED = 2'd0;
  localparam arb_state_t ST_LOCK0 = 2'd1;
  localparam arb_state_t ST_LOCK1 = 2'd2;
  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  function automatic arb_state_t lock_state(input logic id);
    return id ? ST_LOCK1 : ST_LOCK0;
  endfunction
endpackage

// File: rtl/rb1_port_arbiter_if.sv
// rb1_port_arbiter_if: one requester's request/response bundle toward the RB1 arbiter
interface rb1_port_arbiter_if
  import rb1_port_arbiter_pkg::*;
#(
  parameter int AW = RB_AW,
  parameter int DW = RB_DW
);
  logic          req;
  logic          lock;
  logic          rw;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic          err;
  modport master (output req, lock, rw, addr, wdata, input gnt, rvalid, err);
  modport slave (input req, lock, rw, addr, wdata, output gnt, rvalid, err);
endinterface

// File: rtl/rb1_port_arbiter_rr_pick2.sv
// rb1_port_arbiter_rr_pick2: two-way round-robin chooser; ptr names the last winner, which loses a tie
module rb1_port_arbiter_rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic win_valid,
  output logic win_id
);
  // a tie goes to the master that did not win last
  always_comb begin
    win_valid = req0 | req1;
    win_id = (req0 & req1) ? ~ptr : req1;
  end
endmodule

// File: rtl/rb1_port_arbiter.sv
// rb1_port_arbiter: round-robin / burst-lock sharing of register bank RB1 between frame reader m0 and host writer m1
module rb1_port_arbiter
  import rb1_port_arbiter_pkg::*;
#(
  parameter int AW = RB_AW,
  parameter int DW = RB_DW,
  parameter int ADDR_MAX = RB_ADDR_MAX
) (
  input  logic              clk,
  input  logic              rst,
  rb1_port_arbiter_if.slave m0,
  rb1_port_arbiter_if.slave m1,
  output logic [DW-1:0]     rdata,
  output logic              RB1_RW,
  output logic [AW-1:0]     RB1_A,
  output logic [DW-1:0]     RB1_D,
  input  logic [DW-1:0]     RB1_Q
);
  localparam logic [AW-1:0] LAST_WORD = AW'(ADDR_MAX);
  arb_state_t    st_q, st_d;
  logic          rr_q, rr_d, rd_q, rd_d, oor_q, oor_d, rw_q, rw_d;
  logic [1:0]    gnt_q, gnt_d, rvalid_q, rvalid_d, err_q, err_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] d_q, d_d, rdata_q, rdata_d;
  logic          pick_valid, pick_id, win_valid, win_id, w_lock, w_rw, w_oor;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  rb1_port_arbiter_rr_pick2 u_pick (
    .req0      (m0.req),
    .req1      (m1.req),
    .ptr       (rr_q),
    .win_valid (pick_valid),
    .win_id    (pick_id)
  );

  // pick the winner (a held lock overrides round-robin) and form the next registered bank command
  always_comb begin
    win_valid = (st_q == ST_LOCK0) ? m0.req : (st_q == ST_LOCK1) ? m1.req : pick_valid;
    win_id = (st_q == ST_LOCK0) ? 1'b0 : (st_q == ST_LOCK1) ? 1'b1 : pick_id;
    w_lock = win_id ? m1.lock : m0.lock;
    w_rw = win_id ? m1.rw : m0.rw;
    w_addr = win_id ? m1.addr : m0.addr;
    w_wdata = win_id ? m1.wdata : m0.wdata;
    w_oor = w_addr > LAST_WORD;
    st_d = (win_valid && w_lock) ? lock_state(win_id) : ST_UNLOCKED;
    rr_d = win_valid ? win_id : rr_q;
    gnt_d = win_valid ? (win_id ? 2'b10 : 2'b01) : 2'b00;
    rw_d = (win_valid && w_rw == RW_WRITE && !w_oor) ? RW_WRITE : RW_READ;
    a_d = win_valid ? w_addr : a_q;
    d_d = win_valid ? w_wdata : d_q;
    rd_d = win_valid && w_rw == RW_READ;
    oor_d = win_valid && w_oor;
  end

  // retire the command the bank executed this cycle: capture read data, schedule rvalid/err
  always_comb begin
    rvalid_d = rd_q ? gnt_q : 2'b00;
    err_d = oor_q ? gnt_q : 2'b00;
    rdata_d = rd_q ? (oor_q ? '0 : RB1_Q) : rdata_q;
  end

  // arbitration and pipeline state; reset discards any read still in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= ST_UNLOCKED;
      rr_q <= 1'b1;
      gnt_q <= 2'b00;
      rvalid_q <= 2'b00;
      err_q <= 2'b00;
      rd_q <= 1'b0;
      oor_q <= 1'b0;
      rw_q <= RW_READ;
      a_q <= '0;
      d_q <= '0;
      rdata_q <= '0;
    end else begin
      st_q <= st_d;
      rr_q <= rr_d;
      gnt_q <= gnt_d;
      rvalid_q <= rvalid_d;
      err_q <= err_d;
      rd_q <= rd_d;
      oor_q <= oor_d;
      rw_q <= rw_d;
      a_q <= a_d;
      d_q <= d_d;
      rdata_q <= rdata_d;
    end
  end

  assign m0.gnt = gnt_q[0];
  assign m1.gnt = gnt_q[1];
  assign m0.rvalid = rvalid_q[0];
  assign m1.rvalid = rvalid_q[1];
  assign m0.err = err_q[0];
  assign m1.err = err_q[1];
  assign rdata = rdata_q;
  assign RB1_RW = rw_q;
  assign RB1_A = a_q;
  assign RB1_D = d_q;
endmodule
